// File: rtl/matrix_kbd_pkg.sv
// Types and helpers shared by the matrix_kbd scanner and its keypad emulator.
// No logic of its own: key code field extraction and the emulator state encoding.
package matrix_kbd_pkg;

   localparam int KBD_ROWS = 4;
   localparam int KBD_COLS = 4;

   typedef logic [3:0] key_code_t;

   typedef enum logic [2:0] {
      EMU_IDLE,
      EMU_PRESS_BNC,
      EMU_HOLD,
      EMU_REL_BNC,
      EMU_GAP
   } kbd_emu_state_e;

   function automatic logic [1:0] key_row(input key_code_t code);
      return code[3:2];
   endfunction

   function automatic logic [1:0] key_col(input key_code_t code);
      return code[1:0];
   endfunction

endpackage

// File: rtl/kbd_emu_timer.sv
// Loadable down-counter for emulator phases; load has priority, counting stops at zero.
// Load value visible the cycle after load; zero flag is combinational from the count.
module kbd_emu_timer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && !zero) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/matrix_kbd_emu.sv
// Passive 4x4 keypad model: accepts one key request, then closes its contact with press/release bounce.
// Row->column path is combinational; key_ready_o stays low until the inter-key gap has elapsed.
module matrix_kbd_emu
   import matrix_kbd_pkg::*;
#(
   parameter int ROWS           = KBD_ROWS,
   parameter int COLS           = KBD_COLS,
   parameter int HOLD_CYCLES    = 1000,
   parameter int GAP_CYCLES     = 500,
   parameter int BOUNCE_PERIOD  = 16,
   parameter int BOUNCE_TOGGLES = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            key_valid_i,
   input  logic [3:0]      key_code_i,
   output logic            key_ready_o,
   input  logic            abort_i,
   input  logic [ROWS-1:0] row_i,
   output logic [COLS-1:0] column_o,
   output logic            pressed_o,
   output logic            busy_o
);

   localparam int HG_MAX    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int MAX_PHASE = (HG_MAX > BOUNCE_PERIOD) ? HG_MAX : BOUNCE_PERIOD;
   localparam int TW        = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
   localparam int BW        = (BOUNCE_TOGGLES > 1) ? $clog2(BOUNCE_TOGGLES) : 1;
   localparam bit NO_BNC    = (BOUNCE_TOGGLES == 0);

   localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] BNC_LD  = TW'(BOUNCE_PERIOD - 1);
   localparam logic [BW-1:0] TOG_LD  = NO_BNC ? '0 : BW'(BOUNCE_TOGGLES - 1);

   kbd_emu_state_e state, state_n;
   key_code_t      code_q;
   logic [BW-1:0]  tog_cnt;
   logic           tog_load, tog_dec, tog_zero;
   logic           tmr_load, tmr_zero, go_rel, contact;
   logic [TW-1:0]  tmr_val;

   kbd_emu_timer #(.W(TW)) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (busy_o),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= EMU_IDLE;
         code_q  <= '0;
         tog_cnt <= '0;
      end else begin
         state <= state_n;
         if (state == EMU_IDLE && key_valid_i) begin
            code_q <= key_code_i;
         end
         if (tog_load) begin
            tog_cnt <= TOG_LD;
         end else if (tog_dec) begin
            tog_cnt <= tog_cnt - 1'b1;
         end
      end
   end

   assign tog_zero = (tog_cnt == '0);

   always_comb begin
      state_n  = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tog_load = 1'b0;
      tog_dec  = 1'b0;
      go_rel   = 1'b0;
      unique case (state)
         EMU_IDLE: begin
            // A handshake takes priority over abort_i, which is simply not looked at here.
            if (key_valid_i) begin
               tmr_load = 1'b1;
               if (NO_BNC) begin
                  state_n = EMU_HOLD;
                  tmr_val = HOLD_LD;
               end else begin
                  state_n  = EMU_PRESS_BNC;
                  tmr_val  = BNC_LD;
                  tog_load = 1'b1;
               end
            end
         end
         EMU_PRESS_BNC: begin
            if (abort_i) begin
               go_rel = 1'b1;
            end else if (tmr_zero) begin
               tmr_load = 1'b1;
               if (tog_zero) begin
                  state_n = EMU_HOLD;
                  tmr_val = HOLD_LD;
               end else begin
                  tog_dec = 1'b1;
                  tmr_val = BNC_LD;
               end
            end
         end
         EMU_HOLD: begin
            go_rel = abort_i | tmr_zero;
         end
         EMU_REL_BNC: begin
            if (tmr_zero) begin
               tmr_load = 1'b1;
               if (tog_zero) begin
                  state_n = EMU_GAP;
                  tmr_val = GAP_LD;
               end else begin
                  tog_dec = 1'b1;
                  tmr_val = BNC_LD;
               end
            end
         end
         EMU_GAP: begin
            if (tmr_zero) begin
               state_n = EMU_IDLE;
            end
         end
         default: state_n = EMU_IDLE;
      endcase
      if (go_rel) begin
         tmr_load = 1'b1;
         if (NO_BNC) begin
            state_n = EMU_GAP;
            tmr_val = GAP_LD;
         end else begin
            state_n  = EMU_REL_BNC;
            tmr_val  = BNC_LD;
            tog_load = 1'b1;
         end
      end
   end

   // Toggle count starts odd (BOUNCE_TOGGLES is even), so its LSB gives 1,0,1,0 on press.
   always_comb begin
      contact = 1'b0;
      case (state)
         EMU_PRESS_BNC: contact = tog_cnt[0];
         EMU_HOLD:      contact = 1'b1;
         EMU_REL_BNC:   contact = ~tog_cnt[0];
         default:       contact = 1'b0;
      endcase
   end

   always_comb begin
      column_o                  = '0;
      column_o[key_col(code_q)] = contact & row_i[key_row(code_q)];
   end

   assign key_ready_o = (state == EMU_IDLE);
   assign busy_o      = (state != EMU_IDLE);
   assign pressed_o   = (state == EMU_HOLD);

endmodule

// File: tb/tb_matrix_kbd_emu.sv
// Bench for matrix_kbd_emu: one bouncing instance and one bounce-free instance, random keys/rows/aborts
// compared cycle by cycle against a phase-arithmetic model of the keypress timeline.
module tb_matrix_kbd_emu;

   localparam int H = 20;
   localparam int G = 10;
   localparam int P = 3;
   localparam int T = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, abort;
   logic [3:0] key_code, row;
   logic       valid_a, valid_b, ready_a, ready_b, pressed_a, pressed_b, busy_a, busy_b;
   logic [3:0] column_a, column_b;

   int errors = 0;
   int checks = 0;

   matrix_kbd_emu #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(T)) dut_a (
      .clk_i(clk), .rst_i(rst), .key_valid_i(valid_a), .key_code_i(key_code), .key_ready_o(ready_a),
      .abort_i(abort), .row_i(row), .column_o(column_a), .pressed_o(pressed_a), .busy_o(busy_a)
   );

   matrix_kbd_emu #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .BOUNCE_PERIOD(P), .BOUNCE_TOGGLES(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .key_valid_i(valid_b), .key_code_i(key_code), .key_ready_o(ready_b),
      .abort_i(abort), .row_i(row), .column_o(column_b), .pressed_o(pressed_b), .busy_o(busy_b)
   );

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Phase of cycle n after the handshake: 0 press bounce, 1 hold, 2 release bounce, 3 gap, 4 idle.
   // rs is the first release cycle, pt the length of one bounce phase.
   function automatic int phase_of(int n, int rs, int pt);
      if (n < rs) return (n <= pt) ? 0 : 1;
      if (n < rs + pt) return 2;
      if (n < rs + pt + G) return 3;
      return 4;
   endfunction

   function automatic bit contact_of(int n, int rs, int pt);
      case (phase_of(n, rs, pt))
         0: return ((n - 1) / P) % 2 == 0;
         1: return 1'b1;
         2: return ((n - rs) / P) % 2 == 1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic check_outputs(input bit sel, input string tag, input logic [3:0] col,
                                input bit prs, input bit bsy);
      check({tag, "_column"}, sel ? column_b : column_a, col);
      check({tag, "_pressed"}, {3'b000, sel ? pressed_b : pressed_a}, {3'b000, prs});
      check({tag, "_busy"}, {3'b000, sel ? busy_b : busy_a}, {3'b000, bsy});
      check({tag, "_ready"}, {3'b000, sel ? ready_b : ready_a}, {3'b000, !bsy});
   endtask

   // mode: 0 row of the key held, 1 one-hot scan, 2 random rows. abort_at/rst_at 0 = none.
   task automatic run_key(input bit sel, input logic [3:0] code, input int mode, input int abort_at,
                          input bit chain, input logic [3:0] next_code, input int rst_at);
      int pt, rs, last, ph;
      logic [3:0] exp_col;
      pt   = sel ? 0 : P * T;
      rs   = (abort_at > 0) ? abort_at + 1 : pt + H + 1;
      last = rs + pt + G - 1;
      key_code = code;
      valid_a  = !sel;
      valid_b  = sel;
      abort    = ($urandom_range(0, 1) == 1);
      row      = 4'($urandom);
      #1;
      check_outputs(sel, "handshake", 4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      for (int n = 1; n <= last; n++) begin
         valid_a  = chain && !sel;
         valid_b  = chain && sel;
         key_code = chain ? next_code : 4'($urandom);
         case (mode)
            0:       row = 4'b0001 << code[3:2];
            1:       row = 4'b0001 << ((n - 1) % 4);
            default: row = 4'($urandom);
         endcase
         abort = (n == abort_at) || (n >= rs && $urandom_range(0, 1) == 1);
         #1;
         ph      = phase_of(n, rs, pt);
         exp_col = (contact_of(n, rs, pt) && row[code[3:2]]) ? (4'b0001 << code[1:0]) : 4'b0000;
         check_outputs(sel, "active", exp_col, ph == 1, 1'b1);
         if (n == rst_at) begin
            valid_a = 1'b0;
            valid_b = 1'b0;
            abort   = 1'b0;
            #1 rst = 1'b1;
            #1;
            check_outputs(sel, "async_reset", 4'b0000, 1'b0, 1'b0);
            @(posedge clk);
            #1 rst = 1'b0;
            #1;
            check_outputs(sel, "after_reset", 4'b0000, 1'b0, 1'b0);
            return;
         end
         @(posedge clk);
         #1;
      end
      abort   = 1'b0;
      valid_a = chain && !sel;
      valid_b = chain && sel;
      row     = 4'($urandom);
      #1;
      check_outputs(sel, "gap_done", 4'b0000, 1'b0, 1'b0);
   endtask

   initial begin
      logic [3:0] c1, c2;
      int ab;
      rst      = 1'b1;
      abort    = 1'b0;
      valid_a  = 1'b0;
      valid_b  = 1'b0;
      key_code = 4'h0;
      row      = 4'b1111;
      #1;
      check_outputs(1'b0, "reset_a", 4'b0000, 1'b0, 1'b0);
      check_outputs(1'b1, "reset_b", 4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      run_key(1'b0, 4'h6, 0, 0, 1'b0, 4'h0, 0);
      run_key(1'b0, 4'h6, 1, 0, 1'b0, 4'h0, 0);

      c1 = 4'($urandom);
      c2 = ~c1;
      run_key(1'b0, c1, 2, 0, 1'b1, c2, 0);
      run_key(1'b0, c2, 2, 0, 1'b0, 4'h0, 0);

      run_key(1'b0, 4'h6, 0, P * T + 5, 1'b0, 4'h0, 0);
      run_key(1'b0, 4'($urandom), 0, $urandom_range(1, P * T), 1'b0, 4'h0, 0);

      for (int i = 0; i < 4; i++) begin
         ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, P * T + H) : 0;
         run_key(1'b0, 4'($urandom), $urandom_range(0, 2), ab, 1'b0, 4'h0, 0);
      end

      run_key(1'b0, 4'h6, 0, 0, 1'b0, 4'h0, P * T + 8);

      run_key(1'b1, 4'hF, 0, 0, 1'b0, 4'h0, 0);
      run_key(1'b1, 4'($urandom), 2, $urandom_range(1, H), 1'b0, 4'h0, 0);
      run_key(1'b1, 4'($urandom), 1, 0, 1'b0, 4'h0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
